// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encodings and width for the 64-bit ALU
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  localparam int ALU_WIDTH = 64;

endpackage

// File: rtl/alu_1bit.sv
// rtl/alu_1bit.sv - one ALU slice: NOR, XOR, full add or full subtract
module alu_1bit
  import alu_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_NOR: s = ~(x | y);
      OP_XOR: s = x ^ y;
      OP_ADD: begin
        s    = x ^ y ^ cin;
        cout = (x & y) | (cin & (x ^ y));
      end
      OP_SUB: begin
        // cin carries the borrow-in here; cout is the borrow-out
        s    = x ^ y ^ cin;
        cout = (~x & y) | (~(x ^ y) & cin);
      end
      default: begin
        s    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_64bit.sv
// rtl/alu_64bit.sv - ripple-chained 64-bit ALU with registered result and carry
module alu_64bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_1bit u_slice (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (carry[i]),
      .op   (op),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Logic ops never report a carry, whatever the slices leave on the chain
  always_comb begin
    s_d    = sum;
    cout_d = 1'b0;
    if (op == OP_ADD || op == OP_SUB) cout_d = carry[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_alu_64bit.sv
// tb/tb_alu_64bit.sv - scoreboard bench for alu_64bit against a 65-bit reference
module tb_alu_64bit;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [1:0]  op;
  logic [63:0] s;
  logic        cout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];

  alu_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .op    (op),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic mc, input logic [1:0] mop);
    case (mop)
      2'b00:   return {1'b0, ~(ma | mb)};
      2'b01:   return {1'b0, ma ^ mb};
      2'b10:   return {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
      default: return {1'b0, ma} - {1'b0, mb} - {64'd0, mc};
    endcase
  endfunction

  task automatic drive(input logic [63:0] da, input logic [63:0] db,
                       input logic dc, input logic [1:0] dop);
    a   = da;
    b   = db;
    cin = dc;
    op  = dop;
    exp_q.push_back(model(da, db, dc, dop));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
      op  = 2'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if ({cout, s} !== 65'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got cout=%0b s=%h, want 0", i, cout, s);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_logic();
    logic [63:0] va[2];
    logic [63:0] vb[2];
    logic [64:0] want[2];
    logic [64:0] e;
    va[0] = 64'd0;                 vb[0] = 64'd0;
    va[1] = 64'hFFFF_0000_FFFF_0000; vb[1] = 64'h0F0F_0F0F_0F0F_0F0F;
    want[0] = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    want[1] = {1'b0, 64'hF0F0_0F0F_F0F0_0F0F};
    for (int i = 0; i < 2; i++) begin
      drive(va[i], vb[i], 1'(i), 2'(i));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, s} !== want[i] || e !== want[i]) begin
        n_fail++;
        $display("FAIL logic[%0d]: got cout=%0b s=%h, want cout=%0b s=%h",
                 i, cout, s, want[i][64], want[i][63:0]);
      end
    end
  endtask

  task automatic test_arith();
    logic [63:0] va[7];
    logic [63:0] vb[7];
    logic        vc[7];
    logic [1:0]  vo[7];
    logic [64:0] want[7];
    logic [64:0] e;
    va[0] = 64'd5;                  vb[0] = 64'd7;  vc[0] = 0; vo[0] = 2'b10; want[0] = {1'b0, 64'd12};
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'd0;  vc[1] = 1; vo[1] = 2'b10; want[1] = {1'b1, 64'd0};
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vc[2] = 0; vo[2] = 2'b10;
    want[2] = {1'b1, 64'd0};
    va[3] = 64'd10; vb[3] = 64'd3; vc[3] = 0; vo[3] = 2'b11; want[3] = {1'b0, 64'd7};
    va[4] = 64'd10; vb[4] = 64'd3; vc[4] = 1; vo[4] = 2'b11; want[4] = {1'b0, 64'd6};
    va[5] = 64'd0;  vb[5] = 64'd1; vc[5] = 0; vo[5] = 2'b11; want[5] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    va[6] = 64'd5;  vb[6] = 64'd5; vc[6] = 1; vo[6] = 2'b11; want[6] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], vc[i], vo[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, s} !== want[i] || e !== want[i]) begin
        n_fail++;
        $display("FAIL arith[%0d]: got cout=%0b s=%h, want cout=%0b s=%h",
                 i, cout, s, want[i][64], want[i][63:0]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [64:0] e;
    drive('1, '1, 1'b1, 2'b10);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({cout, s} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_fail++;
      $display("FAIL add_all_ones: got cout=%0b s=%h, want cout=1 s=ffffffffffffffff", cout, s);
    end
    drive(64'd0, 64'd0, 1'b1, 2'b11);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({cout, s} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_fail++;
      $display("FAIL sub_zero_borrow: got cout=%0b s=%h, want cout=1 s=ffffffffffffffff", cout, s);
    end
    // cin must not leak into a logic-op result or carry
    drive(64'h1234_5678_9ABC_DEF0, 64'h0FF0_0FF0_0FF0_0FF0, 1'b1, 2'b00);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({cout, s} !== {1'b0, ~(64'h1234_5678_9ABC_DEF0 | 64'h0FF0_0FF0_0FF0_0FF0)}) begin
      n_fail++;
      $display("FAIL nor_cin_ignored: got cout=%0b s=%h, want cout=0 s=%h", cout, s, e[63:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq[4];
    logic [64:0] e;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), seq[i]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if ({cout, s} !== e) begin
          n_fail++;
          $display("FAIL b2b[%0d.%0d]: got cout=%0b s=%h, want cout=%0b s=%h",
                   r, i, cout, s, e[64], e[63:0]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [64:0] e;
    drive(64'd5, 64'd7, 1'b0, 2'b10);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({cout, s} !== {1'b0, 64'd12}) begin
      n_fail++;
      $display("FAIL async_pre: got cout=%0b s=%h, want cout=0 s=c", cout, s);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cout, s} !== 65'd0) begin
      n_fail++;
      $display("FAIL async_drop: got cout=%0b s=%h, want 0", cout, s);
    end
    a = '1; b = '1; cin = 1'b1; op = 2'b10;
    @(posedge clk);
    #1;
    n_checks++;
    if ({cout, s} !== 65'd0) begin
      n_fail++;
      $display("FAIL async_hold: got cout=%0b s=%h, want 0", cout, s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(64'd10, 64'd3, 1'b0, 2'b11);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({cout, s} !== {1'b0, 64'd7}) begin
      n_fail++;
      $display("FAIL async_release: got cout=%0b s=%h, want cout=0 s=7", cout, s);
    end
  endtask

  task automatic test_random();
    logic [64:0] e;
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({cout, s} !== e) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: a=%h b=%h cin=%0b op=%0d got cout=%0b s=%h, want cout=%0b s=%h",
                   i, a, b, cin, op, cout, s, e[64], e[63:0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 2'b00;
    test_reset();
    test_logic();
    test_arith();
    test_boundary();
    test_back_to_back();
    test_async_reset();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
